// File: rtl/fft_frame_reader_pkg.sv
// Shared FFT definitions: default widths, frame reader state encoding and the
// address bit-reverse helper used by both the frame reader and the reorder logic.
package fft_frame_reader_pkg;

    localparam int FFT_ADDR_WIDTH = 10;
    localparam int FFT_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Reverses the low 'width' bits of val; bits above 'width' come back as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] val, input int width);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res[5'(width - 1 - i)] = val[5'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_skid_buf2.sv
// Two-entry FIFO-ordered skid buffer; head entry drives the output with zero added latency.
// Upstream has no ready: the producer must never push into a full buffer.
module fft_skid_buf2 #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign out_vld = (count_q != 2'd0);
    assign out_dat = head_q;
    assign count   = count_q;
    assign pop     = out_vld & out_rdy;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({in_vld, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = in_dat;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = in_dat;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push and pop together: occupancy unchanged, queue shifts by one.
                if (count_q == 2'd1) begin
                    head_d = in_dat;
                end else begin
                    head_d = tail_q;
                    tail_d = in_dat;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fft_frame_reader.sv
// Streams one 2**ADDR_WIDTH-word frame from the sample RAM, natural or bit-reversed order;
// first word valid 2 edges after the start edge, 1 word/cycle sustained under backpressure.
module fft_frame_reader
    import fft_frame_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  frame_ready,
    input  logic                  bitrev_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overrun
);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  bitrev_q, bitrev_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic [1:0]            skid_count;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH:0]   head_dat;
    logic                  head_last;
    logic                  pop;
    logic                  issue;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] c,
                                                      input logic br);
        return br ? ADDR_WIDTH'(bit_reverse(32'(c), ADDR_WIDTH)) : c;
    endfunction

    assign pop       = out_valid & out_ready;
    // Words buffered or in the RAM pipe after this edge; issuing keeps it at most 2.
    assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ST_READ) && (occupancy < 3'd2);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rd_addr_d       = rd_addr_q;
        bitrev_d        = bitrev_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        pending_d       = pending_q;
        overrun_d       = overrun_q;
        frame_done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_ready || pending_q) begin
                    state_d   = ST_READ;
                    cnt_d     = '0;
                    rd_addr_d = addr_of('0, bitrev_en);
                    bitrev_d  = bitrev_en;
                    pending_d = pending_q & frame_ready;
                end
            end
            ST_READ: begin
                if (issue) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (cnt_q == '1);
                    if (cnt_q == '1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d     = cnt_q + 1'b1;
                        rd_addr_d = addr_of(cnt_q + 1'b1, bitrev_q);
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // One start can be queued behind the running frame; any further one is lost.
        if ((state_q != ST_IDLE) && frame_ready) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            rd_addr_q       <= '0;
            bitrev_q        <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            pending_q       <= 1'b0;
            overrun_q       <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rd_addr_q       <= rd_addr_d;
            bitrev_q        <= bitrev_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            pending_q       <= pending_d;
            overrun_q       <= overrun_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    fft_skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk     (rd_clk),
        .rst     (rd_rst),
        .in_vld  (inflight_q),
        .in_dat  ({inflight_last_q, rd_data}),
        .out_vld (out_valid),
        .out_dat (head_dat),
        .out_rdy (out_ready),
        .count   (skid_count)
    );

    assign out_data   = head_dat[DATA_WIDTH-1:0];
    assign head_last  = head_dat[DATA_WIDTH];
    assign out_last   = out_valid & head_last;
    assign rd_addr    = rd_addr_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed bench for fft_frame_reader with a RAM model and an expected-word scoreboard.
module tb_fft_frame_reader;

    localparam int AW = 10;
    localparam int DW = 12;
    localparam int N  = 1 << AW;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          frame_ready;
    logic          bitrev_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;
    logic          busy;
    logic          overrun;

    always #5 rd_clk = ~rd_clk;

    fft_frame_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .frame_ready (frame_ready),
        .bitrev_en   (bitrev_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    logic [DW-1:0] mem [0:N-1];
    always @(posedge rd_clk) rd_data <= mem[rd_addr];

    int            tests    = 0;
    int            fails    = 0;
    int            hs_total = 0;
    int            done_cnt = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] got_q[$];
    bit            capture  = 1'b0;
    bit            stall    = 1'b0;
    logic [DW:0]   held     = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
        return r;
    endfunction

    task automatic push_frame(input bit br);
        for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = br ? rev(AW'(i)) : AW'(i);
            exp_q.push_back({(i == N - 1), mem[a]});
        end
    endtask

    // Stream monitor, evaluated at the falling edge before the handshake edge.
    task automatic sample();
        logic [DW:0] e;
        if (rd_rst === 1'b1) begin
            stall = 1'b0;
        end else begin
            if (stall)
                chk("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("word", 32'({out_last, out_data}), 32'(e));
                end
                if (capture) got_q.push_back(out_data);
                hs_total++;
            end
            stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            held  = {out_last, out_data};
        end
    endtask

    task automatic step();
        @(negedge rd_clk);
        sample();
        @(posedge rd_clk);
        #1;
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic pulse();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int mode, input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((n % 4) == 0) || ((n % 4) == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            step();
            n++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        out_ready = 1'b1;
        chk({tag, "_frame_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int gaps;
        int vcnt;
        int base;
        int d0;
        int n;

        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        out_ready   = 1'b1;
        frame_ready = 1'b0;
        bitrev_en   = 1'b0;
        rd_rst      = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        rd_rst = 1'b0;
        step();

        // Natural order, no backpressure: latency, gapless stream, done timing.
        push_frame(1'b0);
        pulse();
        chk("t1_busy_start", 32'(busy), 32'd1);
        chk("t1_valid_e0", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid_e1", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid_e2", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'(out_data), 32'd0);
        gaps = 0;
        for (int i = 0; i < N; i++) begin
            if (out_valid !== 1'b1) gaps++;
            step();
        end
        chk("t1_gaps", 32'(gaps), 32'd0);
        chk("t1_frame_done", 32'(frame_done), 32'd1);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        step();
        chk("t1_done_pulse_end", 32'(frame_done), 32'd0);

        // Bit-reversed order; bitrev_en drops right after the start edge.
        bitrev_en = 1'b1;
        push_frame(1'b1);
        got_q.delete();
        capture = 1'b1;
        pulse();
        bitrev_en = 1'b0;
        wait_done(3000, 0, "t2");
        capture = 1'b0;
        chk("t2_count", 32'(got_q.size()), 32'(N));
        if (got_q.size() == N) begin
            chk("t2_word0", 32'(got_q[0]), 32'd0);
            chk("t2_word1", 32'(got_q[1]), 32'd512);
            chk("t2_word2", 32'(got_q[2]), 32'd256);
            chk("t2_word3", 32'(got_q[3]), 32'd768);
            chk("t2_word1023", 32'(got_q[N-1]), 32'd1023);
        end

        // Backpressure: fixed 1,0,0,1 pattern then random.
        for (int m = 1; m <= 2; m++) begin
            base = hs_total;
            push_frame(1'b0);
            pulse();
            wait_done(10000, m, "t3");
            chk("t3_handshakes", 32'(hs_total - base), 32'(N));
            chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // One extra start during a frame queues the next frame.
        push_frame(1'b0);
        push_frame(1'b0);
        pulse();
        repeat (100) step();
        pulse();
        wait_done(3000, 0, "t4a");
        step();
        chk("t4_restart_busy", 32'(busy), 32'd1);
        wait_done(3000, 0, "t4b");
        chk("t4_no_overrun", 32'(overrun), 32'd0);

        // Two extra starts: overrun, only two frames.
        push_frame(1'b0);
        push_frame(1'b0);
        d0 = done_cnt;
        pulse();
        repeat (50) step();
        pulse();
        repeat (50) step();
        pulse();
        chk("t5_overrun", 32'(overrun), 32'd1);
        wait_done(3000, 0, "t5a");
        wait_done(3000, 0, "t5b");
        vcnt = 0;
        repeat (60) begin
            step();
            vcnt += int'(out_valid);
        end
        chk("t5_idle_valid", 32'(vcnt), 32'd0);
        chk("t5_frames", 32'(done_cnt - d0), 32'd2);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame at word 500.
        push_frame(1'b0);
        base = hs_total;
        pulse();
        n = 0;
        while ((hs_total - base) < 500 && n < 3000) begin
            step();
            n++;
        end
        chk("t6_words_before_rst", 32'(hs_total - base), 32'd500);
        rd_rst = 1'b1;
        step();
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_last", 32'(out_last), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(frame_done), 32'd0);
        chk("t6_rst_addr", 32'(rd_addr), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        rd_rst = 1'b0;
        exp_q.delete();
        vcnt = 0;
        repeat (20) begin
            step();
            vcnt += int'(out_valid);
        end
        chk("t6_no_valid_after_rst", 32'(vcnt), 32'd0);
        push_frame(1'b0);
        pulse();
        wait_done(3000, 0, "t6");
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        // frame_ready on the same edge as frame_done.
        push_frame(1'b0);
        push_frame(1'b0);
        pulse();
        repeat (N + 1) step();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("t7_done_coincident", 32'(frame_done), 32'd1);
        step();
        chk("t7_valid_f1", 32'(out_valid), 32'd0);
        chk("t7_busy_f1", 32'(busy), 32'd1);
        step();
        chk("t7_valid_f2", 32'(out_valid), 32'd0);
        step();
        chk("t7_valid_f3", 32'(out_valid), 32'd1);
        wait_done(3000, 0, "t7");
        chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_frame_reader.md
Name: fft_frame_reader

Overview:
- Drains one 1024 x 12 sample frame from the simple dual-port sample RAM (read side, 1-cycle read latency, no output register) into the FFT core input.
- Data is delivered as a valid/ready stream, in natural or bit-reversed address order.
- A frame is triggered by a one-cycle pulse from the write-side capture logic.
- Absorbs downstream backpressure with a 2-entry skid buffer, so that 1 word/cycle throughput is sustained.

Parameters:
- ADDR_WIDTH, 10, RAM read address width; frame length = 2**ADDR_WIDTH.
- DATA_WIDTH, 12, RAM read data width and stream width.

Ports:
- rd_clk  input  1  single clock, shared with the RAM read port.
- rd_rst  input  1  synchronous active-high reset.
- frame_ready  input  1  one-cycle pulse: a complete frame is in RAM.
- bitrev_en  input  1  1 = read in bit-reversed address order; sampled only when a frame starts.
- rd_addr  output  ADDR_WIDTH  RAM read address, registered.
- rd_data  input  DATA_WIDTH  RAM read data; reflects the address sampled at the previous edge.
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the FFT core.
- out_last  output  1  high with the final (1024th) word of the frame.
- frame_done  output  1  one-cycle pulse on the edge after the last word's handshake.
- busy  output  1  high from frame start until frame_done.
- overrun  output  1  sticky; set when frame_ready arrives while one start is already pending. Cleared only by rd_rst.

Behaviour:
- Reset values:
  - rd_addr = 0, out_valid = 0, out_last = 0, frame_done = 0, busy = 0, overrun = 0.
  - FSM = IDLE; skid buffer empty; in-flight flag = 0; pending flag = 0.
  - rd_rst wins over every other event, including mid-frame. The partial frame is discarded and nothing further is emitted.
- The RAM reads on every edge (no read enable). An "issue" is the block's internal record that the current rd_addr was sampled. Data is written into the skid buffer one edge later, only if the in-flight flag is set.
- Address generation:
  - cnt counts 0..1023.
  - rd_addr = cnt when the latched bitrev mode is 0; otherwise rd_addr = bit-reverse(cnt) over ADDR_WIDTH bits.
  - rd_addr holds its value while not issuing.
- Issue rule at each edge in READ state: issue iff (skid_count + inflight - pop) < 2, where pop = out_valid && out_ready. On issue, cnt increments.
- FSM:
  - IDLE: on frame_ready (or pending flag set) go to READ. At that edge: cnt = 0, rd_addr = addr(0), latch bitrev_en, busy = 1, clear pending.
  - READ: issue per the rule. When word 1023 is issued, go to DRAIN.
  - DRAIN: no issues. When the handshake with out_last occurs, go to IDLE and pulse frame_done on that edge. busy falls on the same edge.
- Latency:
  - With out_ready held at 1, out_valid rises on the 2nd edge after the edge that samples frame_ready.
  - The stream then runs 1 word/cycle with no gaps, for 1024 consecutive cycles.
- Skid buffer:
  - 2 entries, FIFO order; out_data/out_valid come from the head entry.
  - out_last is tagged on the entry whose issue index was 1023.
  - A simultaneous push and pop keeps the count unchanged.
- Stream rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - The skid buffer never overflows (guaranteed by the issue rule).
- frame_ready while busy: set pending (at most one). A second frame_ready while pending is set also sets overrun; the extra start is dropped.
- frame_ready on the same edge as frame_done: becomes pending; the next frame starts on the following edge.

Decomposition:
- Shared FFT package holds:
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - FSM state encoding {IDLE, READ, DRAIN};
  - a bit-reverse function of ADDR_WIDTH bits (reused by the FFT reorder logic).
- One sub-module, fft_skid_buf2: 2-entry valid/ready buffer with a DATA_WIDTH+1 payload (data plus last tag).

Test Plan:
- Natural order, out_ready=1, RAM[i]=i:
  - frame_ready pulse → out_valid rises 2 edges later.
  - 1024 gapless words 0..1023; out_last only on 1023; frame_done 1 cycle after it; busy falls on the same edge.
- Bit-reversed order, RAM[i]=i, bitrev_en=1:
  - word 0 = 0, word 1 = 512, word 2 = 256, word 3 = 768, word 1023 = 1023.
- Backpressure, out_ready toggling 1,0,0,1 repeatedly plus random patterns:
  - no word lost or duplicated; data held stable while stalled; exactly 1024 handshakes.
- frame_ready during a frame:
  - one pulse → second frame starts on the edge after frame_done.
  - two pulses → overrun=1 and only 2 frames are emitted.
- rd_rst asserted at word 500:
  - outputs return to reset values on the next edge; no further out_valid.
  - a new frame_ready restarts from address 0.
- frame_ready coincident with frame_done:
  - next frame's first out_valid appears 3 edges after frame_done.
